dpbram_be: RTL

Parametrised true dual-port block RAM with per-byte write enables, selectable read-during-write behaviour and an optional output pipeline register. It replaces the single-port buffer RAM wherever two agents share one buffer, for example a producer writing line data on port A while a consumer reads on port B. Both ports run on one clock. Memory contents are not reset.

---
 rtl/dpbram_be.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dpbram_be.sv
// dpbram_be: true dual-port block RAM with per-byte write enables.
//
// Two ports (A and B) share one clock and one word array. Each port can read
// or write one word per cycle; writes update only the byte lanes selected by
// be_x. Port A wins byte lanes written by both ports to the same word. A read
// that collides with the other port's write returns the pre-write word.
// RDW_MODE selects what a port's own write returns on q_x.
// OUT_REG adds a second output stage (latency 2 instead of 1).
// Memory contents are never reset.
//
// Ports (x = a, b):
//   clk        rising-edge clock for all logic
//   rst_n      synchronous active-low reset (outputs/pipeline only)
//   addr_x     word address
//   ce_x       access enable
//   we_x       1 = write, 0 = read
//   be_x       byte write enables, bit i covers d_x[8i+7:8i]
//   d_x        write data
//   q_x        read data (holds between qualifying accesses)
//   q_valid_x  one-cycle pulse when q_x was updated
module dpbram_be #(
    parameter int    DWIDTH   = 32,
    parameter int    AWIDTH   = 12,
    parameter int    MEM_SIZE = 3840,
    parameter int    OUT_REG  = 0,
    parameter string RDW_MODE = "READ_FIRST"
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AWIDTH-1:0]   addr_a,
    input  logic                ce_a,
    input  logic                we_a,
    input  logic [DWIDTH/8-1:0] be_a,
    input  logic [DWIDTH-1:0]   d_a,
    output logic [DWIDTH-1:0]   q_a,
    output logic                q_valid_a,
    input  logic [AWIDTH-1:0]   addr_b,
    input  logic                ce_b,
    input  logic                we_b,
    input  logic [DWIDTH/8-1:0] be_b,
    input  logic [DWIDTH-1:0]   d_b,
    output logic [DWIDTH-1:0]   q_b,
    output logic                q_valid_b
);

    localparam int NB = DWIDTH / 8;
    localparam bit MODE_WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
    localparam bit MODE_NO_CHANGE   = (RDW_MODE == "NO_CHANGE");
    // One extra bit so MEM_SIZE == 2^AWIDTH still compares correctly.
    localparam logic [AWIDTH:0] ADDR_LIMIT = (AWIDTH + 1)'(MEM_SIZE);

    logic [DWIDTH-1:0] mem [MEM_SIZE];

    // Port signals packed per port index (0 = A, 1 = B) for the shared read path.
    logic [1:0][AWIDTH-1:0] addr_s;
    logic [1:0]             ce_s;
    logic [1:0]             we_s;
    logic [1:0][NB-1:0]     be_s;
    logic [1:0][DWIDTH-1:0] d_s;
    logic [1:0][DWIDTH-1:0] q_s;
    logic [1:0]             v_s;
    logic [1:0]             in_range_s;
    logic [1:0]             wr_s;

    assign addr_s = {addr_b, addr_a};
    assign ce_s   = {ce_b, ce_a};
    assign we_s   = {we_b, we_a};
    assign be_s   = {be_b, be_a};
    assign d_s    = {d_b, d_a};

    assign in_range_s[0] = ({1'b0, addr_a} < ADDR_LIMIT);
    assign in_range_s[1] = ({1'b0, addr_b} < ADDR_LIMIT);
    // Out-of-range writes are dropped; reset suppresses writes.
    assign wr_s[0] = rst_n & ce_a & we_a & in_range_s[0];
    assign wr_s[1] = rst_n & ce_b & we_b & in_range_s[1];

    assign q_a       = q_s[0];
    assign q_valid_a = v_s[0];
    assign q_b       = q_s[1];
    assign q_valid_b = v_s[1];

    // Replace the byte lanes of old_w selected by be with those of new_w.
    function automatic logic [DWIDTH-1:0] merge_bytes(
        input logic [DWIDTH-1:0] old_w,
        input logic [DWIDTH-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DWIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Byte-lane memory writes; port B is applied first so port A's lanes win
    // when both ports write the same word in one cycle.
    always_ff @(posedge clk) begin
        if (wr_s[1]) begin
            for (int i = 0; i < NB; i++) begin
                if (be_b[i]) begin
                    mem[addr_b][8*i +: 8] <= d_b[8*i +: 8];
                end
            end
        end
        if (wr_s[0]) begin
            for (int i = 0; i < NB; i++) begin
                if (be_a[i]) begin
                    mem[addr_a][8*i +: 8] <= d_a[8*i +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DWIDTH-1:0] rd_s;
        logic [DWIDTH-1:0] merged_s;
        logic [DWIDTH-1:0] q1_nxt_s;
        logic              v1_nxt_s;
        logic [DWIDTH-1:0] q1_r;
        logic              v1_r;

        // rd_s is the pre-write word, so cross-port collisions read old data.
        assign rd_s     = in_range_s[p] ? mem[addr_s[p]] : {DWIDTH{1'b0}};
        assign merged_s = in_range_s[p] ? merge_bytes(rd_s, d_s[p], be_s[p])
                                        : {DWIDTH{1'b0}};

        // Stage-1 next value: read data, or the RDW-mode result on a write.
        always_comb begin
            q1_nxt_s = q1_r;
            v1_nxt_s = 1'b0;
            if (ce_s[p]) begin
                if (!we_s[p]) begin
                    q1_nxt_s = rd_s;
                    v1_nxt_s = 1'b1;
                end else if (MODE_NO_CHANGE) begin
                    q1_nxt_s = q1_r;
                    v1_nxt_s = 1'b0;
                end else if (MODE_WRITE_FIRST) begin
                    q1_nxt_s = merged_s;
                    v1_nxt_s = 1'b1;
                end else begin
                    q1_nxt_s = rd_s;
                    v1_nxt_s = 1'b1;
                end
            end else begin
                q1_nxt_s = q1_r;
                v1_nxt_s = 1'b0;
            end
        end

        // Stage-1 output register; reset also discards in-flight reads.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q1_r <= {DWIDTH{1'b0}};
                v1_r <= 1'b0;
            end else begin
                q1_r <= q1_nxt_s;
                v1_r <= v1_nxt_s;
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [DWIDTH-1:0] q2_r;
            logic              v2_r;

            // Stage-2 register: copies stage 1 every cycle for full throughput.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q2_r <= {DWIDTH{1'b0}};
                    v2_r <= 1'b0;
                end else begin
                    q2_r <= q1_r;
                    v2_r <= v1_r;
                end
            end

            assign q_s[p] = q2_r;
            assign v_s[p] = v2_r;
        end else begin : g_noreg
            assign q_s[p] = q1_r;
            assign v_s[p] = v1_r;
        end
    end

endmodule
